// File: rtl/pattern_mealy_over.sv
// Overlapping Mealy detector for the serial sequence 1,1,0,1,0 (oldest bit first).
// One-hot state advances only on qualified bits; the detection pulse is combinational.
module pattern_mealy_over #(
  parameter logic [4:0] S_RESET = 5'b00001,
  parameter logic [4:0] S_B     = 5'b00010,
  parameter logic [4:0] S_BB    = 5'b00100,
  parameter logic [4:0] S_BBC   = 5'b01000,
  parameter logic [4:0] S_BBCB  = 5'b10000
) (
  input  logic clk,
  input  logic rst,
  input  logic data_i,
  input  logic valid_i,
  output logic pattern_o
);

  logic [4:0] state_reg;
  logic [4:0] state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  // Unqualified bits hold a legal state; any corrupted encoding falls back to idle.
  always_comb begin
    state_next = S_RESET;
    case (state_reg)
      S_RESET: state_next = !valid_i ? S_RESET : (data_i ? S_B    : S_RESET);
      S_B:     state_next = !valid_i ? S_B     : (data_i ? S_BB   : S_RESET);
      S_BB:    state_next = !valid_i ? S_BB    : (data_i ? S_BB   : S_BBC);
      S_BBC:   state_next = !valid_i ? S_BBC   : (data_i ? S_BBCB : S_RESET);
      S_BBCB:  state_next = !valid_i ? S_BBCB  : (data_i ? S_BB   : S_RESET);
      default: state_next = S_RESET;
    endcase
  end

  assign pattern_o = (state_reg == S_BBCB) && valid_i && !data_i && !rst;

endmodule

// File: tb/tb_pattern_mealy_over.sv
// Self-checking bench: a sliding-window model of the last five qualified bits
// is compared against pattern_o every cycle, plus literal pulse-position masks.
module tb_pattern_mealy_over;

  logic clk = 1'b0;
  logic rst;
  logic data_i;
  logic valid_i;
  logic pattern_o;

  pattern_mealy_over dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .pattern_o(pattern_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: last four qualified bits since reset, and how many have been seen.
  logic [3:0] hist = 4'b0;
  int hist_len = 0;
  int model_hits = 0;
  int dut_rises = 0;
  logic prev_pat = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_out(input logic v, input logic d);
    return v && !rst && (hist_len >= 4) && ({hist, d} == 5'b11010);
  endfunction

  task automatic model_clear();
    hist = 4'b0;
    hist_len = 0;
  endtask

  // One clock cycle: drive at the falling edge, compare just before the rising edge.
  task automatic step(input logic v, input logic d, input string tag, output logic pat);
    logic exp;
    @(negedge clk);
    valid_i = v;
    data_i  = d;
    #4;
    exp = model_out(v, d);
    check({tag, " cycle"}, {31'b0, pattern_o}, {31'b0, exp});
    pat = pattern_o;
    if (pattern_o === 1'b1 && prev_pat !== 1'b1) dut_rises++;
    prev_pat = pattern_o;
    if (exp) model_hits++;
    if (v) begin
      hist = {hist[2:0], d};
      if (hist_len < 4) hist_len++;
    end
  endtask

  // '1'/'0' are qualified bits, 'x'/'y' are unqualified cycles with data 1/0.
  // exp_mask bit i is the hand-computed pulse at character i.
  task automatic run_seq(input string s, input logic [31:0] exp_mask, input string name);
    logic [31:0] mask;
    logic pat;
    mask = '0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "1": step(1'b1, 1'b1, name, pat);
        "0": step(1'b1, 1'b0, name, pat);
        "x": step(1'b0, 1'b1, name, pat);
        default: step(1'b0, 1'b0, name, pat);
      endcase
      if (pat === 1'b1) mask[i] = 1'b1;
    end
    check({name, " mask"}, mask, exp_mask);
    $display("seq %-12s stream=%s pulses=%b", name, s, mask);
  endtask

  initial begin
    logic pat;
    int rand_hits_start;
    int rand_rises_start;

    rst = 1'b1;
    valid_i = 1'b1;
    data_i = 1'b0;
    #1;
    check("reset pattern", {31'b0, pattern_o}, 32'd0);
    step(1'b1, 1'b0, "in_reset", pat);
    step(1'b1, 1'b1, "in_reset", pat);
    @(negedge clk);
    rst = 1'b0;
    valid_i = 1'b0;
    model_clear();
    $display("reset released");

    run_seq("11010", 32'b10000, "single");
    run_seq("1101011010", 32'b1000010000, "back2back");
    run_seq("11011010", 32'b10000000, "overlap");
    run_seq("11xyx010", 32'b10000000, "gap");
    run_seq("1111010", 32'b1000000, "long_ones");
    run_seq("101000", 32'b0, "no_match");
    run_seq("yyyxxx", 32'b0, "idle");

    // Mid-sequence asynchronous reset after prefix 1101.
    run_seq("1101", 32'b0, "prefix");
    @(negedge clk);
    valid_i = 1'b1;
    data_i = 1'b0;
    #1;
    check("pre_reset pulse", {31'b0, pattern_o}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async reset pulse", {31'b0, pattern_o}, 32'd0);
    model_clear();
    prev_pat = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    valid_i = 1'b0;
    $display("reset pulsed mid-sequence");
    run_seq("0", 32'b0, "after_reset");
    run_seq("11010", 32'b10000, "fresh");

    // Random stream, then idle.
    rand_hits_start = model_hits;
    rand_rises_start = dut_rises;
    for (int i = 0; i < 600; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), "random", pat);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), "drop", pat);
      check("idle after random", {31'b0, pattern_o}, 32'd0);
    end
    check("random pulse count", dut_rises - rand_rises_start, model_hits - rand_hits_start);
    $display("random 600 bits: model hits=%0d dut rises=%0d",
             model_hits - rand_hits_start, dut_rises - rand_rises_start);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
